// File: rtl/rds_stream_mixer.sv
// Joins the 57 kHz bandpass stream (s00) with the tripled-pilot carrier (s01) and emits the
// rounded, saturated signed product. Per-channel FIFOs absorb skew; pairs are joined in arrival order.

module rds_mixer_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdata;
  end

  assign rdata = mem[rp];
  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
endmodule

module rds_stream_mixer #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_S01_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH             = 8,
  parameter int PRODUCT_SHIFT          = 31,
  parameter int DROP_ON_FULL           = 0
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_areset,
  input  logic                                s00_axis_tvalid,
  output logic                                s00_axis_tready,
  input  logic                                s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                                s01_axis_tvalid,
  output logic                                s01_axis_tready,
  input  logic [C_S01_AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
  output logic                                m00_axis_tvalid,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  input  logic [1:0]                          mix_mode,
  input  logic                                flush,
  output logic [15:0]                         drop_count_a,
  output logic [15:0]                         drop_count_b,
  output logic [15:0]                         sat_count
);
  localparam int A_W = C_S00_AXIS_TDATA_WIDTH;
  localparam int B_W = C_S01_AXIS_TDATA_WIDTH;
  localparam int O_W = C_M00_AXIS_TDATA_WIDTH;
  localparam int P_W = A_W + B_W;
  localparam int R_W = P_W + 1;
  localparam int E_W = (R_W > O_W) ? R_W : O_W;
  localparam int RS  = (PRODUCT_SHIFT > 0) ? PRODUCT_SHIFT - 1 : 0;
  localparam logic signed [R_W-1:0] RND  = (PRODUCT_SHIFT > 0) ? (R_W'(1) <<< RS) : '0;
  localparam logic signed [E_W-1:0] OMAX = E_W'({1'b0, {(O_W-1){1'b1}}});
  localparam logic signed [E_W-1:0] OMIN = ~OMAX;

  logic [A_W:0]   fa_rdata;
  logic [B_W-1:0] fb_rdata;
  logic           fa_empty, fa_full, fb_empty, fb_full;
  logic           wr_a, wr_b, drop_a, drop_b, join_p, stall;
  logic [2:1]     vld_pipe;

  logic signed [P_W-1:0] a_ext, b_ext, s1_in, s1_prod;
  logic                  s1_last;
  logic signed [R_W-1:0] rnd;
  logic signed [E_W-1:0] shr;
  logic                  sat_hi, sat_lo;
  logic [O_W-1:0]        o_val;

  // Ready never looks at the output side, so a read from a full FIFO frees space only next cycle.
  assign s00_axis_tready = !s00_axis_areset && ((DROP_ON_FULL != 0) || !fa_full);
  assign s01_axis_tready = !s00_axis_areset && ((DROP_ON_FULL != 0) || !fb_full);
  assign wr_a   = s00_axis_tvalid && s00_axis_tready && !fa_full && !flush;
  assign wr_b   = s01_axis_tvalid && s01_axis_tready && !fb_full && !flush;
  assign drop_a = s00_axis_tvalid && s00_axis_tready &&  fa_full && !flush;
  assign drop_b = s01_axis_tvalid && s01_axis_tready &&  fb_full && !flush;

  assign stall  = vld_pipe[2] && !m00_axis_tready;
  assign join_p = !fa_empty && !fb_empty && !stall && !flush;

  rds_mixer_fifo #(.W(A_W+1), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk(s00_axis_aclk), .rst(s00_axis_areset), .flush(flush), .wr(wr_a), .rd(join_p),
    .wdata({s00_axis_tlast, s00_axis_tdata}), .rdata(fa_rdata), .empty(fa_empty), .full(fa_full));

  rds_mixer_fifo #(.W(B_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk(s00_axis_aclk), .rst(s00_axis_areset), .flush(flush), .wr(wr_b), .rd(join_p),
    .wdata(s01_axis_tdata), .rdata(fb_rdata), .empty(fb_empty), .full(fb_full));

  assign a_ext = {{B_W{fa_rdata[A_W-1]}}, fa_rdata[A_W-1:0]};
  assign b_ext = {{A_W{fb_rdata[B_W-1]}}, fb_rdata};

  // Bypass operands are pre-shifted so S2 applies the same rounding shift to every mode.
  always_comb begin
    case (mix_mode)
      2'b01:   s1_in = a_ext <<< PRODUCT_SHIFT;
      2'b10:   s1_in = b_ext <<< PRODUCT_SHIFT;
      default: s1_in = a_ext * b_ext;
    endcase
  end

  assign rnd    = {s1_prod[P_W-1], s1_prod} + RND;
  assign shr    = E_W'(rnd >>> PRODUCT_SHIFT);
  assign sat_hi = shr > OMAX;
  assign sat_lo = shr < OMIN;
  assign o_val  = sat_hi ? OMAX[O_W-1:0] : (sat_lo ? OMIN[O_W-1:0] : shr[O_W-1:0]);

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      vld_pipe       <= '0;
      s1_prod        <= '0;
      s1_last        <= 1'b0;
      m00_axis_tdata <= '0;
      m00_axis_tlast <= 1'b0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[1], join_p};
      if (join_p) begin
        s1_prod <= s1_in;
        s1_last <= fa_rdata[A_W];
      end
      if (vld_pipe[1]) begin
        m00_axis_tdata <= o_val;
        m00_axis_tlast <= s1_last;
      end
    end
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      drop_count_a <= '0;
      drop_count_b <= '0;
      sat_count    <= '0;
    end else begin
      if (drop_a) drop_count_a <= sat_inc(drop_count_a);
      if (drop_b) drop_count_b <= sat_inc(drop_count_b);
      if (!flush && !stall && vld_pipe[1] && (sat_hi || sat_lo)) sat_count <= sat_inc(sat_count);
    end
  end

  assign m00_axis_tvalid = vld_pipe[2];
  assign m00_axis_tstrb  = '1;
endmodule

// File: tb/tb_rds_stream_mixer.sv
// Bench for rds_stream_mixer: queue-based pairing model checked on every output beat, plus
// directed literal checks for latency, rounding, saturation, drops, flush and reset.

module tb_rds_stream_mixer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 0, a_last = 0, b_valid = 0, m_ready = 1, flush = 0;
  logic [31:0] a_data = 0, b_data = 0;
  logic [1:0]  mode = 0;
  logic        a_ready, b_ready, m_valid, m_last;
  logic [31:0] m_data;
  logic [3:0]  m_strb;
  logic [15:0] dropa, dropb, satc;

  logic        da_valid = 0, db_valid = 0;
  logic [31:0] da_data = 0, db_data = 0;
  logic        da_ready, db_ready, dm_valid, dm_last;
  logic [31:0] dm_data;
  logic [3:0]  dm_strb;
  logic [15:0] d_dropa, d_dropb, d_satc;

  int checks = 0, failures = 0;
  int n_out = 0, n_last = 0, ia = 0, ib = 0;

  always #5 clk = ~clk;

  rds_stream_mixer dut (
    .s00_axis_aclk(clk), .s00_axis_areset(rst),
    .s00_axis_tvalid(a_valid), .s00_axis_tready(a_ready), .s00_axis_tlast(a_last), .s00_axis_tdata(a_data),
    .s01_axis_tvalid(b_valid), .s01_axis_tready(b_ready), .s01_axis_tdata(b_data),
    .m00_axis_tvalid(m_valid), .m00_axis_tready(m_ready), .m00_axis_tlast(m_last),
    .m00_axis_tdata(m_data), .m00_axis_tstrb(m_strb),
    .mix_mode(mode), .flush(flush),
    .drop_count_a(dropa), .drop_count_b(dropb), .sat_count(satc));

  rds_stream_mixer #(.DROP_ON_FULL(1)) dut_d (
    .s00_axis_aclk(clk), .s00_axis_areset(rst),
    .s00_axis_tvalid(da_valid), .s00_axis_tready(da_ready), .s00_axis_tlast(1'b0), .s00_axis_tdata(da_data),
    .s01_axis_tvalid(db_valid), .s01_axis_tready(db_ready), .s01_axis_tdata(db_data),
    .m00_axis_tvalid(dm_valid), .m00_axis_tready(1'b1), .m00_axis_tlast(dm_last),
    .m00_axis_tdata(dm_data), .m00_axis_tstrb(dm_strb),
    .mix_mode(2'b01), .flush(1'b0),
    .drop_count_a(d_dropa), .drop_count_b(d_dropb), .sat_count(d_satc));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference mixing: exact product, round half up at bit 31, clamp to int32.
  function automatic logic [31:0] mix(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    longint p;
    if (m == 2'b01) return a;
    if (m == 2'b10) return b;
    p = longint'($signed(a)) * longint'($signed(b));
    p = (p + (longint'(1) <<< 30)) >>> 31;
    if (p > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (p < -64'sd2147483648) return 32'h8000_0000;
    return p[31:0];
  endfunction

  logic [32:0] qa[$];
  logic [31:0] qb[$];
  logic [32:0] qe[$];
  bit          prev_stall = 0, prev_flush = 0;
  logic [32:0] prev_out = '0;

  always @(negedge clk) begin
    logic [32:0] ea, ee;
    logic [31:0] eb;
    if (rst) begin
      qa.delete(); qb.delete(); qe.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall && !prev_flush) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", {m_last, m_data}, prev_out);
      end
      if (m_valid && m_ready) begin
        n_out++;
        if (m_last) n_last++;
        if (qe.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out: got %0h expected no output", m_data);
        end else begin
          ee = qe.pop_front();
          chk("out", {m_last, m_data}, ee);
        end
      end
      if (flush) begin
        qa.delete(); qb.delete(); qe.delete();
      end else begin
        if (a_valid && a_ready) qa.push_back({a_last, a_data});
        if (b_valid && b_ready) qb.push_back(b_data);
        while (qa.size() > 0 && qb.size() > 0) begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          qe.push_back({ea[32], mix(ea[31:0], eb, mode)});
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_flush = flush;
      prev_out   = {m_last, m_data};
    end
  end

  logic [31:0] dq[$];
  always @(negedge clk) if (!rst && dm_valid) dq.push_back(dm_data);

  task automatic send(input bit ua, input bit ub, input logic [31:0] a, input logic [31:0] b,
                      input bit last, output int ne);
    bit pa, pb;
    pa = ua; pb = ub; ne = 0;
    a_valid = ua; a_data = a; a_last = last; b_valid = ub; b_data = b;
    while ((pa || pb) && ne < 200) begin
      @(negedge clk);
      if (a_valid && a_ready) pa = 0;
      if (b_valid && b_ready) pb = 0;
      @(posedge clk); #1;
      ne++;
      if (!pa) a_valid = 0;
      if (!pb) b_valid = 0;
    end
    a_valid = 0; b_valid = 0; a_last = 0;
    if (pa || pb) begin
      checks++; failures++;
      $display("FAIL send_timeout: got no handshake expected one within 200 cycles");
    end
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (qe.size() == 0 && !m_valid) ok = 1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drain: got %0d samples pending expected 0", qe.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic get_out(input string nm, input logic [31:0] expd);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (m_valid) seen = 1;
    end
    chk({nm, "_seen"}, seen, 1);
    chk({nm, "_data"}, m_data, expd);
    @(posedge clk); #1;
  endtask

  task automatic pair_out(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [31:0] expd);
    int ne;
    send(1, 1, a, b, 0, ne);
    get_out(nm, expd);
    drain();
  endtask

  task automatic lat_pair(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [31:0] expd);
    int ne;
    send(1, 1, a, b, 0, ne);
    chk({nm, "_accept_edges"}, ne, 1);
    chk({nm, "_valid_e0"}, m_valid, 0);
    @(posedge clk); #1;
    chk({nm, "_valid_e1"}, m_valid, 0);
    @(posedge clk); #1;
    chk({nm, "_valid_e2"}, m_valid, 1);
    chk({nm, "_data"}, m_data, expd);
    drain();
  endtask

  task automatic stream(input int n);
    bit ga, gb;
    a_valid = 1; b_valid = 1;
    a_data = 32'h0100_0000 * (ia + 1);
    b_data = 32'hF000_0000 + 32'h0012_3457 * ib;
    repeat (n) begin
      @(negedge clk);
      ga = a_valid && a_ready;
      gb = b_valid && b_ready;
      @(posedge clk); #1;
      if (ga) begin ia++; a_data = 32'h0100_0000 * (ia + 1); end
      if (gb) begin ib++; b_data = 32'hF000_0000 + 32'h0012_3457 * ib; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ne, n0, l0;
    #1 rst = 1;
    repeat (2) @(posedge clk); #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_sat", satc, 0);
    chk("rst_drop", {dropa, dropb}, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("a_ready_idle", a_ready, 1);
    chk("strb", m_strb, 4'hF);

    lat_pair("t1", 32'h4000_0000, 32'h4000_0000, 32'h2000_0000);
    chk("t1_sat", satc, 0);

    pair_out("t2_pos_sat", 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF);
    chk("t2_sat", satc, 1);
    pair_out("t2_min", 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0001);
    pair_out("t2_round", 32'hFFFF_FFFD, 32'h4000_0000, 32'hFFFF_FFFF);
    chk("t2_sat_once", satc, 1);
    mode = 2'b01; pair_out("mode_a", 32'h0000_1234, 32'h0000_0005, 32'h0000_1234);
    mode = 2'b10; pair_out("mode_b", 32'h0000_1234, 32'h0000_0005, 32'h0000_0005);
    mode = 2'b11; pair_out("mode_p", 32'h4000_0000, 32'h4000_0000, 32'h2000_0000);
    mode = 2'b00;

    // Skewed arrival: five signal beats, carrier twenty cycles later.
    n0 = n_out; l0 = n_last;
    for (int k = 1; k <= 5; k++) send(1, 0, 32'h1000_0000 * k, 0, k == 5, ne);
    repeat (20) @(posedge clk); #1;
    chk("t3_no_out_yet", n_out - n0, 0);
    for (int k = 1; k <= 5; k++) send(0, 1, 0, 32'h7FFF_FFF0 - k, 0, ne);
    drain();
    chk("t3_count", n_out - n0, 5);
    chk("t3_last", n_last - l0, 1);

    // Backpressure: both FIFOs plus two pipeline stages fill, then everything drains.
    n0 = n_out; ia = 0; ib = 0; m_ready = 0;
    stream(20);
    chk("t4_a_full", a_ready, 0);
    chk("t4_b_full", b_ready, 0);
    chk("t4_a_taken", ia, 10);
    chk("t4_b_taken", ib, 10);
    m_ready = 1;
    stream(15);
    a_valid = 0; b_valid = 0;
    drain();
    chk("t4_count_a", n_out - n0, ia);
    chk("t4_count_b", n_out - n0, ib);

    // Drop mode on the second instance.
    for (int k = 1; k <= 12; k++) begin da_valid = 1; da_data = k; @(posedge clk); #1; end
    da_valid = 0;
    chk("t5_drop_a", d_dropa, 4);
    chk("t5_drop_b", d_dropb, 0);
    chk("t5_ready_full", da_ready, 1);
    for (int k = 1; k <= 8; k++) begin db_valid = 1; db_data = 100 + k; @(posedge clk); #1; end
    db_valid = 0;
    repeat (10) @(posedge clk); #1;
    chk("t5_count", dq.size(), 8);
    for (int k = 0; k < 8 && k < dq.size(); k++) chk("t5_data", dq[k], k + 1);

    // Flush mid-burst with a concurrent input beat.
    ia = 0; ib = 0;
    stream(6);
    flush = 1;
    @(posedge clk); #1;
    flush = 0; a_valid = 0; b_valid = 0;
    chk("t6f_valid", m_valid, 0);
    chk("t6f_a_ready", a_ready, 1);
    chk("t6f_sat_kept", satc, 1);
    chk("t6f_drop_kept", d_dropa, 4);
    repeat (4) @(posedge clk); #1;
    chk("t6f_still_idle", m_valid, 0);
    lat_pair("t6f", 32'h4000_0000, 32'h2000_0000, 32'h1000_0000);

    // Asynchronous reset mid-burst.
    stream(6);
    #2 rst = 1;
    #1;
    chk("t6r_valid", m_valid, 0);
    chk("t6r_data", m_data, 0);
    chk("t6r_a_ready", a_ready, 0);
    chk("t6r_sat", satc, 0);
    chk("t6r_drop", d_dropa, 0);
    a_valid = 0; b_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    lat_pair("t6r", 32'hC000_0000, 32'h4000_0000, 32'hE000_0000);
    chk("t6r_sat_after", satc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
